wb_classic_regfile: RTL and testbench



---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_byte_reg.sv | 32 +++
 rtl/wb_classic_regfile.sv | 156 +++++++++++++++
 tb/tb_wb_classic_regfile.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone classic definitions: FSM states and response classes.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_t;

  typedef enum logic [1:0] {
    RESP_ACK = 2'd0,
    RESP_ERR = 2'd1,
    RESP_RTY = 2'd2
  } wb_resp_t;

endpackage

// File: rtl/wb_byte_reg.sv
// One data register with per-byte-lane write enables and a synchronous reset value.
module wb_byte_reg #(
  parameter int                   DAT_WIDTH   = 32,
  parameter logic [DAT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DAT_WIDTH/8-1:0] lane_we,
  input  logic [DAT_WIDTH-1:0]   wdata,
  output logic [DAT_WIDTH-1:0]   q
);

  localparam int LANES = DAT_WIDTH / 8;

  logic [DAT_WIDTH-1:0] q_r;

  // Lane-wise register update; unselected lanes hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_r <= RESET_VALUE;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_we[i]) begin
          q_r[8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign q = q_r;

endmodule

// File: rtl/wb_classic_regfile.sv
// Wishbone B4 classic register-file device: byte-writable registers, registered
// single-cycle responses, programmable wait states and ack/err/rty classification.
module wb_classic_regfile
  import wb_pkg::*;
#(
  parameter int                   DAT_WIDTH   = 32,
  parameter int                   ADR_WIDTH   = 8,
  parameter int                   NUM_REGS    = 16,
  parameter int                   WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter logic [DAT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cyc_i,
  input  logic                          stb_i,
  input  logic                          we_i,
  input  logic [ADR_WIDTH-1:0]          adr_i,
  input  logic [DAT_WIDTH/8-1:0]        sel_i,
  input  logic [DAT_WIDTH-1:0]          dat_i,
  input  logic                          busy_i,
  output logic [DAT_WIDTH-1:0]          dat_o,
  output logic                          ack_o,
  output logic                          err_o,
  output logic                          rty_o,
  output logic [NUM_REGS*DAT_WIDTH-1:0] regs_o
);

  localparam int       IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam bit       NO_WAIT   = (WAIT_STATES == 32'sd0);
  localparam bit [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

  wb_state_t            state_r;
  wb_resp_t             resp_r;
  logic [3:0]           cnt_r;
  logic                 we_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 ack_r;
  logic                 err_r;
  logic                 rty_r;
  logic [DAT_WIDTH-1:0] dat_r;

  logic                 req_s;
  logic [IDX_W-1:0]     idx_s;
  wb_resp_t             class_s;
  logic                 go_ack_s;
  wb_resp_t             go_resp_s;
  logic [IDX_W-1:0]     go_idx_s;
  logic                 go_we_s;
  logic                 commit_s;
  logic [DAT_WIDTH-1:0] q_s [NUM_REGS];

  // Out-of-range beats busy, busy beats a read-only write
  function automatic wb_resp_t classify(input logic [ADR_WIDTH-1:0] adr,
                                        input logic we, input logic busy);
    if (32'(adr) >= 32'(NUM_REGS)) begin
      return RESP_ERR;
    end else if (busy) begin
      return RESP_RTY;
    end else if (we && RO_MASK[adr[IDX_W-1:0]]) begin
      return RESP_ERR;
    end else begin
      return RESP_ACK;
    end
  endfunction

  assign req_s    = cyc_i && stb_i;
  assign idx_s    = adr_i[IDX_W-1:0];
  assign class_s  = classify(adr_i, we_i, busy_i);
  assign commit_s = (state_r == ACK) && (resp_r == RESP_ACK) && we_r;

  // Identify the edge entering ACK so the response flops load alongside the state
  always_comb begin
    go_ack_s  = 1'b0;
    go_resp_s = class_s;
    go_idx_s  = idx_s;
    go_we_s   = we_i;
    if ((state_r == IDLE) && req_s && NO_WAIT) begin
      go_ack_s = 1'b1;
    end else if ((state_r == WAIT) && cyc_i && (cnt_r == 4'd0)) begin
      go_ack_s  = 1'b1;
      go_resp_s = resp_r;
      go_idx_s  = idx_r;
      go_we_s   = we_r;
    end else begin
      go_ack_s = 1'b0;
    end
  end

  // Transaction FSM and registered termination outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      resp_r  <= RESP_ACK;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      idx_r   <= '0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rty_r   <= 1'b0;
      dat_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            we_r    <= we_i;
            idx_r   <= idx_s;
            resp_r  <= class_s;
            cnt_r   <= WAIT_INIT;
            state_r <= NO_WAIT ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!cyc_i) begin
            state_r <= IDLE;
          end else if (cnt_r == 4'd0) begin
            state_r <= ACK;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ACK:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
      ack_r <= go_ack_s && (go_resp_s == RESP_ACK);
      err_r <= go_ack_s && (go_resp_s == RESP_ERR);
      rty_r <= go_ack_s && (go_resp_s == RESP_RTY);
      dat_r <= (go_ack_s && (go_resp_s == RESP_ACK) && !go_we_s) ? q_s[go_idx_s] : '0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic [DAT_WIDTH/8-1:0] lane_we_s;

    assign lane_we_s = (commit_s && (idx_r == IDX_W'(g))) ? sel_i : '0;

    wb_byte_reg #(
      .DAT_WIDTH  (DAT_WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_reg (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .lane_we(lane_we_s),
      .wdata  (dat_i),
      .q      (q_s[g])
    );

    assign regs_o[g*DAT_WIDTH +: DAT_WIDTH] = q_s[g];
  end

  assign dat_o = dat_r;
  assign ack_o = ack_r;
  assign err_o = err_r;
  assign rty_o = rty_r;

endmodule

// File: tb/tb_wb_classic_regfile.sv
// Self-checking bench: three device instances (0, 3 and 5 wait states) driven by
// directed tables, corner-case sequences and random transactions against a model.
module tb_wb_classic_regfile;

  logic         clk;
  logic         rst   [3];
  logic         cyc   [3];
  logic         stb   [3];
  logic         we    [3];
  logic [7:0]   adr   [3];
  logic [3:0]   sel   [3];
  logic [31:0]  din   [3];
  logic         busy  [3];
  logic [31:0]  dout  [3];
  logic         ack   [3];
  logic         err   [3];
  logic         rty   [3];
  logic [511:0] regs  [3];

  int           checks;
  int           errors;
  int           wst   [3];
  logic [15:0]  ro    [3];
  logic [31:0]  rstv  [3];
  logic [31:0]  mreg  [3][16];

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        busy;
    int          resp;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl [14];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_classic_regfile #(.WAIT_STATES(0), .RO_MASK(16'h0004), .RESET_VALUE(32'h0000_0000)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]), .adr_i(adr[0]),
    .sel_i(sel[0]), .dat_i(din[0]), .busy_i(busy[0]), .dat_o(dout[0]), .ack_o(ack[0]),
    .err_o(err[0]), .rty_o(rty[0]), .regs_o(regs[0]));

  wb_classic_regfile #(.WAIT_STATES(3), .RO_MASK(16'h8000), .RESET_VALUE(32'h0000_0000)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]), .adr_i(adr[1]),
    .sel_i(sel[1]), .dat_i(din[1]), .busy_i(busy[1]), .dat_o(dout[1]), .ack_o(ack[1]),
    .err_o(err[1]), .rty_o(rty[1]), .regs_o(regs[1]));

  wb_classic_regfile #(.WAIT_STATES(5), .RO_MASK(16'h0000), .RESET_VALUE(32'hA5A5_5A5A)) dut2 (
    .clk_i(clk), .rst_i(rst[2]), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]), .adr_i(adr[2]),
    .sel_i(sel[2]), .dat_i(din[2]), .busy_i(busy[2]), .dat_o(dout[2]), .ack_o(ack[2]),
    .err_o(err[2]), .rty_o(rty[2]), .regs_o(regs[2]));

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [511:0] mflat(input int k);
    logic [511:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = mreg[k][i];
    return f;
  endfunction

  // Response class: 0 ack, 1 err, 2 rty
  function automatic int model_resp(input int k, input logic w, input logic [7:0] a, input logic b);
    if (a >= 8'd16) return 1;
    if (b) return 2;
    if (w && ro[k][a[3:0]]) return 1;
    return 0;
  endfunction

  function automatic vec_t mk(input logic w, input logic [7:0] a, input logic [3:0] s,
                              input logic [31:0] d, input logic b, input int r, input logic [31:0] rd);
    vec_t v;
    v.we = w; v.adr = a; v.sel = s; v.dat = d; v.busy = b; v.resp = r; v.rdat = rd;
    return v;
  endfunction

  // One full transaction: 3 = no response seen, 4 = several strobes at once
  task automatic tx(input int k, input logic w, input logic [7:0] a, input logic [3:0] s,
                    input logic [31:0] d, input logic b, input logic flip_b,
                    input int exp_resp, input logic [31:0] exp_dat, input string nm);
    int          got_resp;
    int          got_lat;
    logic [31:0] got_dat;
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; din[k] = d; busy[k] = b;
    got_resp = 3; got_lat = 0; got_dat = 32'h0;
    for (int n = 1; n <= wst[k] + 4 && got_resp == 3; n++) begin
      @(negedge clk);
      if (n == 1 && flip_b) busy[k] = ~b;
      if (int'(ack[k]) + int'(err[k]) + int'(rty[k]) > 1) got_resp = 4;
      else if (ack[k]) got_resp = 0;
      else if (err[k]) got_resp = 1;
      else if (rty[k]) got_resp = 2;
      if (got_resp != 3) begin
        got_lat = n;
        got_dat = dout[k];
      end
    end
    chk({nm, " resp"}, got_resp, exp_resp);
    chk({nm, " latency"}, got_lat, wst[k] + 1);
    chk({nm, " dat_o"}, got_dat, exp_dat);
    @(negedge clk);
    chk({nm, " single pulse"}, {ack[k], err[k], rty[k], dout[k]}, 35'h0);
    cyc[k] = 1'b0; stb[k] = 1'b0; busy[k] = 1'b0;
    if (exp_resp == 0 && w) begin
      for (int i = 0; i < 4; i++) if (s[i]) mreg[k][a[3:0]][8*i +: 8] = d[8*i +: 8];
    end
    chk({nm, " regs_o"}, regs[k], mflat(k));
  endtask

  initial begin
    logic        w;
    logic        b;
    logic        fb;
    logic [7:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] ed;
    logic [5:0]  pat;
    logic        seen;
    int          r;

    checks = 0; errors = 0;
    wst[0] = 0; wst[1] = 3; wst[2] = 5;
    ro[0] = 16'h0004; ro[1] = 16'h8000; ro[2] = 16'h0000;
    rstv[0] = 32'h0; rstv[1] = 32'h0; rstv[2] = 32'hA5A5_5A5A;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      adr[k] = 8'h0; sel[k] = 4'h0; din[k] = 32'h0; busy[k] = 1'b0;
      for (int i = 0; i < 16; i++) mreg[k][i] = rstv[k];
    end

    tbl[0]  = mk(1'b1, 8'd3,   4'hF, 32'hDEAD_BEEF, 1'b0, 0, 32'h0);
    tbl[1]  = mk(1'b0, 8'd3,   4'h0, 32'h0,         1'b0, 0, 32'hDEAD_BEEF);
    tbl[2]  = mk(1'b1, 8'd5,   4'hF, 32'h1122_3344, 1'b0, 0, 32'h0);
    tbl[3]  = mk(1'b1, 8'd5,   4'h5, 32'hAABB_CCDD, 1'b0, 0, 32'h0);
    tbl[4]  = mk(1'b0, 8'd5,   4'hF, 32'h0,         1'b0, 0, 32'h11BB_33DD);
    tbl[5]  = mk(1'b0, 8'd16,  4'hF, 32'h0,         1'b0, 1, 32'h0);
    tbl[6]  = mk(1'b1, 8'd2,   4'hF, 32'h1234_5678, 1'b0, 1, 32'h0);
    tbl[7]  = mk(1'b0, 8'd2,   4'hF, 32'h0,         1'b0, 0, 32'h0);
    tbl[8]  = mk(1'b1, 8'd7,   4'hF, 32'h7777_7777, 1'b1, 2, 32'h0);
    tbl[9]  = mk(1'b0, 8'd7,   4'hF, 32'h0,         1'b0, 0, 32'h0);
    tbl[10] = mk(1'b1, 8'd9,   4'h0, 32'hFFFF_FFFF, 1'b0, 0, 32'h0);
    tbl[11] = mk(1'b0, 8'd9,   4'hF, 32'h0,         1'b0, 0, 32'h0);
    tbl[12] = mk(1'b1, 8'd16,  4'hF, 32'h0,         1'b1, 1, 32'h0);
    tbl[13] = mk(1'b1, 8'd2,   4'hF, 32'h0,         1'b1, 2, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset outputs dut%0d", k), {ack[k], err[k], rty[k], dout[k]}, 35'h0);
      chk($sformatf("reset regs dut%0d", k), regs[k], {16{rstv[k]}});
      rst[k] = 1'b0;
    end

    for (int i = 0; i < 14; i++) begin
      tx(0, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, tbl[i].busy, 1'b0,
         tbl[i].resp, tbl[i].rdat, $sformatf("vec%0d", i));
    end

    // Busy only matters at acceptance
    tx(1, 1'b1, 8'd4, 4'hF, 32'h0102_0304, 1'b1, 1'b1, 2, 32'h0, "rty_w3");
    tx(1, 1'b1, 8'd4, 4'hF, 32'h0102_0304, 1'b0, 1'b1, 0, 32'h0, "ack_w3");
    tx(1, 1'b0, 8'd4, 4'h0, 32'h0,         1'b0, 1'b0, 0, 32'h0102_0304, "rd_w3");

    // Back-to-back writes with stb held: acks in cycles 1, 3, 5
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; adr[0] = 8'd10; din[0] = 32'h1000_000A;
    pat = 6'h0; seen = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      pat[n-1] = ack[0];
      seen = seen | err[0] | rty[0];
      if (n == 2) begin adr[0] = 8'd11; din[0] = 32'h1000_000B; end
      if (n == 4) begin adr[0] = 8'd12; din[0] = 32'h1000_000C; end
      if (n == 6) begin cyc[0] = 1'b0; stb[0] = 1'b0; end
    end
    mreg[0][10] = 32'h1000_000A; mreg[0][11] = 32'h1000_000B; mreg[0][12] = 32'h1000_000C;
    chk("b2b ack pattern", pat, 6'b010101);
    chk("b2b no err/rty", seen, 1'b0);
    chk("b2b regs", regs[0], mflat(0));

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        w  = 1'($urandom_range(0, 1));
        a  = 8'($urandom_range(0, 19));
        s  = 4'($urandom);
        d  = $urandom;
        b  = ($urandom_range(0, 7) == 0);
        fb = 1'($urandom_range(0, 1));
        r  = model_resp(k, w, a, b);
        ed = (r == 0 && !w) ? mreg[k][a[3:0]] : 32'h0;
        tx(k, w, a, s, d, b, fb, r, ed, $sformatf("rnd%0d_%0d", k, i));
      end
    end

    // Abort: cyc drops mid-WAIT, so neither response nor write
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 8'd1; sel[2] = 4'hF; din[2] = 32'hCAFE_F00D;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | ack[2] | err[2] | rty[2];
    end
    cyc[2] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | ack[2] | err[2] | rty[2];
    end
    stb[2] = 1'b0;
    chk("abort no response", seen, 1'b0);
    chk("abort regs", regs[2], mflat(2));

    // Reset mid-WAIT drops the transaction and restores reset values
    tx(2, 1'b1, 8'd6, 4'hF, 32'h6666_6666, 1'b0, 1'b0, 0, 32'h0, "pre_rst");
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 8'd7; sel[2] = 4'hF; din[2] = 32'h7777_7777;
    repeat (2) @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    chk("rst_wait outputs", {ack[2], err[2], rty[2], dout[2]}, 35'h0);
    rst[2] = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
    for (int i = 0; i < 16; i++) mreg[2][i] = rstv[2];
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | ack[2] | err[2] | rty[2];
    end
    chk("rst_wait no response", seen, 1'b0);
    chk("rst_wait regs", regs[2], mflat(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
